// File: rtl/ecc_scrubber.sv
// rtl/ecc_scrubber.sv - background SECDED memory scrubber sequencing an external decoder/encoder
module ecc_scrubber #(
    parameter int K        = 8,
    parameter int CW       = 13,
    parameter int AW       = 8,
    parameter int DEPTH    = 256,
    parameter int INTERVAL = 1024,
    parameter int CNTW     = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            en_i,
    input  logic            clr_i,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [AW-1:0]   mem_adr_o,
    output logic [CW-1:0]   mem_d_o,
    input  logic [CW-1:0]   mem_q_i,
    input  logic            mem_ack_i,
    output logic [CW-1:0]   dec_d_o,
    input  logic [K-1:0]    dec_q_i,
    input  logic            dec_sb_err_i,
    input  logic            dec_db_err_i,
    output logic [K-1:0]    enc_d_o,
    input  logic [CW-1:0]   enc_q_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            db_err_o,
    output logic [AW-1:0]   db_adr_o,
    output logic [CNTW-1:0] sb_cnt_o,
    output logic [CNTW-1:0] db_cnt_o
);

    // Wait counter must hold INTERVAL; keep at least one bit for the back-to-back case.
    localparam int              WW        = (INTERVAL > 0) ? $clog2(INTERVAL + 1) : 1;
    localparam logic [WW-1:0]   WAIT_LOAD = WW'(INTERVAL);
    localparam logic [AW-1:0]   LAST_ADR  = AW'(DEPTH - 1);
    localparam logic [CNTW-1:0] CNT_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_READ,
        S_CHECK,
        S_WRITE,
        S_NEXT
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [WW-1:0]   wait_cnt_q;
    logic [AW-1:0]   adr_q;
    logic [AW-1:0]   mem_adr_q;
    logic [CW-1:0]   rdata_q;
    logic [CW-1:0]   wdata_q;
    logic [AW-1:0]   db_adr_q;
    logic [CNTW-1:0] sb_cnt_q;
    logic [CNTW-1:0] db_cnt_q;

    // The decoder always looks at the captured read word; the encoder re-encodes the corrected bits.
    assign dec_d_o   = rdata_q;
    assign enc_d_o   = dec_q_i;
    assign mem_adr_o = mem_adr_q;
    assign mem_d_o   = wdata_q;
    assign db_adr_o  = db_adr_q;
    assign sb_cnt_o  = sb_cnt_q;
    assign db_cnt_o  = db_cnt_q;

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; en_i is honoured in IDLE and NEXT, and aborts only a pending WAIT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (en_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!en_i) begin
                    state_d = S_IDLE;
                end else if (wait_cnt_q == '0) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (mem_ack_i) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (dec_db_err_i) begin
                    state_d = S_NEXT;
                end else if (dec_sb_err_i) begin
                    state_d = S_WRITE;
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_WRITE: begin
                if (mem_ack_i) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                state_d = en_i ? S_WAIT : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status and memory-strobe outputs decoded from the current state.
    always_comb begin
        mem_req_o = 1'b0;
        mem_we_o  = 1'b0;
        busy_o    = (state_q != S_IDLE);
        done_o    = 1'b0;
        db_err_o  = 1'b0;
        case (state_q)
            S_READ: begin
                mem_req_o = 1'b1;
            end
            S_WRITE: begin
                mem_req_o = 1'b1;
                mem_we_o  = 1'b1;
            end
            S_CHECK: begin
                db_err_o = dec_db_err_i;
            end
            S_NEXT: begin
                done_o = (adr_q == LAST_ADR);
            end
            default: begin
                mem_req_o = 1'b0;
            end
        endcase
    end

    // Inter-word idle counter: reloaded whenever WAIT can be entered, counted down inside WAIT.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wait_cnt_q <= '0;
        end else if (state_q == S_IDLE || state_q == S_NEXT) begin
            wait_cnt_q <= WAIT_LOAD;
        end else if (state_q == S_WAIT && wait_cnt_q != '0) begin
            wait_cnt_q <= wait_cnt_q - WW'(1);
        end
    end

    // Scrub pointer, wrapping after the last word; kept across IDLE so a pass resumes where it stopped.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            adr_q <= '0;
        end else if (state_q == S_NEXT) begin
            adr_q <= (adr_q == LAST_ADR) ? '0 : adr_q + AW'(1);
        end
    end

    // Memory address is latched when a read is launched, so it holds while idle or checking.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mem_adr_q <= '0;
        end else if (state_q == S_WAIT && state_d == S_READ) begin
            mem_adr_q <= adr_q;
        end
    end

    // Read capture; acks outside READ never touch the register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (state_q == S_READ && mem_ack_i) begin
            rdata_q <= mem_q_i;
        end
    end

    // Write-back word: the re-encoded corrected data, taken only when a correction is needed.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wdata_q <= '0;
        end else if (state_q == S_CHECK && !dec_db_err_i && dec_sb_err_i) begin
            wdata_q <= enc_q_i;
        end
    end

    // Error log: saturating counters and last uncorrectable address; clear beats a same-cycle increment.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sb_cnt_q <= '0;
            db_cnt_q <= '0;
            db_adr_q <= '0;
        end else if (clr_i) begin
            sb_cnt_q <= '0;
            db_cnt_q <= '0;
            db_adr_q <= '0;
        end else if (state_q == S_CHECK) begin
            if (dec_db_err_i) begin
                db_adr_q <= adr_q;
                if (db_cnt_q != CNT_MAX) begin
                    db_cnt_q <= db_cnt_q + CNTW'(1);
                end
            end else if (dec_sb_err_i) begin
                if (sb_cnt_q != CNT_MAX) begin
                    sb_cnt_q <= sb_cnt_q + CNTW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ecc_scrubber.sv
// tb/tb_ecc_scrubber.sv - directed scoreboard bench for ecc_scrubber with a behavioural SECDED pair
module tb_ecc_scrubber;

    localparam int K        = 8;
    localparam int CW       = 13;
    localparam int AW       = 8;
    localparam int DEPTH    = 4;
    localparam int INTERVAL = 0;
    localparam int CNTW     = 2;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            en_i;
    logic            clr_i;
    logic            mem_req_o;
    logic            mem_we_o;
    logic [AW-1:0]   mem_adr_o;
    logic [CW-1:0]   mem_d_o;
    logic [CW-1:0]   mem_q_i;
    logic            mem_ack_i;
    logic [CW-1:0]   dec_d_o;
    logic [K-1:0]    dec_q_i;
    logic            dec_sb_err_i;
    logic            dec_db_err_i;
    logic [K-1:0]    enc_d_o;
    logic [CW-1:0]   enc_q_i;
    logic            busy_o;
    logic            done_o;
    logic            db_err_o;
    logic [AW-1:0]   db_adr_o;
    logic [CNTW-1:0] sb_cnt_o;
    logic [CNTW-1:0] db_cnt_o;

    always #5 clk_i = ~clk_i;

    ecc_scrubber #(
        .K(K), .CW(CW), .AW(AW), .DEPTH(DEPTH), .INTERVAL(INTERVAL), .CNTW(CNTW)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .clr_i(clr_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_adr_o(mem_adr_o),
        .mem_d_o(mem_d_o), .mem_q_i(mem_q_i), .mem_ack_i(mem_ack_i),
        .dec_d_o(dec_d_o), .dec_q_i(dec_q_i), .dec_sb_err_i(dec_sb_err_i),
        .dec_db_err_i(dec_db_err_i), .enc_d_o(enc_d_o), .enc_q_i(enc_q_i),
        .busy_o(busy_o), .done_o(done_o), .db_err_o(db_err_o), .db_adr_o(db_adr_o),
        .sb_cnt_o(sb_cnt_o), .db_cnt_o(db_cnt_o)
    );

    // Hamming(12,8) with parity at positions 1,2,4,8 and overall parity in bit 0.
    function automatic logic [3:0] syn_of(input logic [12:0] c);
        logic [3:0] s;
        s = '0;
        for (int i = 1; i < 13; i++) if (c[i]) s ^= 4'(i);
        return s;
    endfunction

    function automatic logic [12:0] enc(input logic [7:0] d);
        logic [12:0] c;
        logic        b;
        c = '0;
        c[3] = d[0]; c[5] = d[1]; c[6] = d[2]; c[7] = d[3];
        c[9] = d[4]; c[10] = d[5]; c[11] = d[6]; c[12] = d[7];
        for (int p = 1; p < 16; p = p * 2) begin
            b = 1'b0;
            for (int i = 1; i < 13; i++) if ((i & p) != 0 && i != p) b ^= c[i];
            c[p] = b;
        end
        c[0] = ^c[12:1];
        return c;
    endfunction

    function automatic logic [7:0] dec_data(input logic [12:0] cw);
        logic [12:0] c;
        logic [3:0]  s;
        c = cw;
        s = syn_of(cw);
        if ((^cw) && s != 4'd0 && s < 4'd13) c[s] = ~c[s];
        return {c[12], c[11], c[10], c[9], c[7], c[6], c[5], c[3]};
    endfunction

    logic [12:0] mem [4];
    logic [7:0]  dat [4];

    assign dec_q_i      = dec_data(dec_d_o);
    assign dec_sb_err_i = ^dec_d_o;
    assign dec_db_err_i = ~(^dec_d_o) & (syn_of(dec_d_o) != 4'd0);
    assign enc_q_i      = enc(enc_d_o);
    assign mem_q_i      = mem[mem_adr_o[1:0]];

    typedef struct {
        logic        we;
        logic [7:0]  adr;
        logic [12:0] d;
    } acc_t;

    acc_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   db_pulses = 0;
    int   len0 = 0;
    logic stray_ack = 1'b0;
    logic ack_delay_adr0 = 1'b0;
    logic ack_hold_adr1 = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic we, input logic [7:0] adr, input logic [12:0] d);
        acc_t e;
        e.we = we; e.adr = adr; e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic push_reads();
        for (int i = 0; i < 4; i++) push(1'b0, 8'(i), '0);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (done_o !== 1'b1 && n < 200);
        check("done_seen", done_o, 1);
    endtask

    task automatic run_pass();
        int n;
        en_i = 1'b1;
        wait_done(n);
        en_i = 1'b0;
        @(negedge clk_i);
        check("idle_after_pass", busy_o, 0);
    endtask

    always @(negedge clk_i) if (db_err_o === 1'b1) db_pulses++;

    // Memory responder: grants acks, checks request stability and pops the access scoreboard.
    initial begin
        int          cnt;
        int          delay;
        logic        s_we;
        logic [7:0]  s_adr;
        logic [12:0] s_d;
        acc_t        e;
        mem_ack_i = 1'b0;
        cnt = 0;
        s_we = 1'b0; s_adr = '0; s_d = '0;
        forever begin
            @(negedge clk_i);
            if (mem_req_o === 1'b1) begin
                if (cnt == 0) begin
                    s_we = mem_we_o; s_adr = mem_adr_o; s_d = mem_d_o;
                end else begin
                    check("req_stable", {mem_we_o, mem_adr_o, mem_d_o}, {s_we, s_adr, s_d});
                end
                delay = (ack_delay_adr0 && mem_adr_o == 8'd0 && !mem_we_o) ? 3 : 0;
                if ((ack_hold_adr1 && mem_adr_o == 8'd1) || cnt < delay) begin
                    mem_ack_i = 1'b0;
                    cnt++;
                end else begin
                    mem_ack_i = 1'b1;
                    if (mem_adr_o == 8'd0 && !mem_we_o) len0 = cnt + 1;
                    tests++;
                    assert (exp_q.size() != 0) else begin
                        fails++;
                        $error("FAIL acc_unexpected: observed we=%0b adr=%0d expected no access", mem_we_o, mem_adr_o);
                    end
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("acc_we", mem_we_o, e.we);
                        check("acc_adr", mem_adr_o, e.adr);
                        if (e.we) check("acc_wdata", mem_d_o, e.d);
                    end
                    if (mem_we_o) mem[mem_adr_o[1:0]] = mem_d_o;
                    cnt = 0;
                end
            end else begin
                mem_ack_i = stray_ack;
                cnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int n2;
        rst_ni = 1'b0; en_i = 1'b0; clr_i = 1'b0;
        dat[0] = 8'hA5; dat[1] = 8'h3C; dat[2] = 8'h0F; dat[3] = 8'hF0;
        for (int i = 0; i < 4; i++) mem[i] = enc(dat[i]);
        repeat (3) @(negedge clk_i);

        check("rst_req", mem_req_o, 0);
        check("rst_we", mem_we_o, 0);
        check("rst_adr", mem_adr_o, 0);
        check("rst_d", mem_d_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_dberr", db_err_o, 0);
        check("rst_dbadr", db_adr_o, 0);
        check("rst_sbcnt", sb_cnt_o, 0);
        check("rst_dbcnt", db_cnt_o, 0);
        check("rst_decd", dec_d_o, 0);

        rst_ni = 1'b1;
        stray_ack = 1'b1;
        repeat (3) @(negedge clk_i);
        stray_ack = 1'b0;
        @(negedge clk_i);
        check("stray_busy", busy_o, 0);
        check("stray_nocapture", dec_d_o, 0);

        // Two clean passes back to back; done spacing is 4 words x 4 cycles.
        push_reads();
        push_reads();
        en_i = 1'b1;
        wait_done(n);
        wait_done(n2);
        check("done_period", n2, 16);
        en_i = 1'b0;
        @(negedge clk_i);
        check("clean_idle", busy_o, 0);
        check("clean_sbcnt", sb_cnt_o, 0);
        check("clean_dbcnt", db_cnt_o, 0);
        check("clean_dbpulses", db_pulses, 0);
        check("clean_q_empty", exp_q.size(), 0);

        // Single data-bit error in word 2 is written back re-encoded.
        mem[2] = mem[2] ^ 13'h0008;
        push(1'b0, 8'd0, '0); push(1'b0, 8'd1, '0); push(1'b0, 8'd2, '0);
        push(1'b1, 8'd2, enc(dat[2])); push(1'b0, 8'd3, '0);
        run_pass();
        check("sb_cnt_1", sb_cnt_o, 1);
        check("sb_mem_fixed", mem[2], enc(dat[2]));
        push_reads();
        run_pass();
        check("sb_cnt_still_1", sb_cnt_o, 1);
        check("sb_q_empty", exp_q.size(), 0);

        // Double-bit error in word 1: logged every pass, never written.
        mem[1] = mem[1] ^ 13'h0028;
        push_reads();
        run_pass();
        check("db_cnt_1", db_cnt_o, 1);
        check("db_adr_1", db_adr_o, 1);
        check("db_pulses_1", db_pulses, 1);
        push_reads();
        run_pass();
        check("db_cnt_2", db_cnt_o, 2);
        check("db_pulses_2", db_pulses, 2);
        check("db_q_empty", exp_q.size(), 0);
        mem[1] = enc(dat[1]);

        // Read of address 0 acked after three wait states.
        ack_delay_adr0 = 1'b1;
        push_reads();
        run_pass();
        ack_delay_adr0 = 1'b0;
        check("wait_req_len", len0, 4);
        check("wait_q_empty", exp_q.size(), 0);

        // en_i dropped during a WRITE: write finishes, scrubbing resumes at word 3.
        mem[2] = mem[2] ^ 13'h0200;
        push(1'b0, 8'd0, '0); push(1'b0, 8'd1, '0); push(1'b0, 8'd2, '0);
        push(1'b1, 8'd2, enc(dat[2]));
        en_i = 1'b1;
        n = 0;
        while (!(mem_req_o === 1'b1 && mem_we_o === 1'b1) && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        check("write_reached", mem_we_o, 1);
        en_i = 1'b0;
        n = 0;
        while (busy_o !== 1'b0 && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check("stop_idle", busy_o, 0);
        check("stop_q_empty", exp_q.size(), 0);
        check("stop_mem_fixed", mem[2], enc(dat[2]));
        check("stop_sbcnt", sb_cnt_o, 2);
        push(1'b0, 8'd3, '0);
        run_pass();
        check("resume_q_empty", exp_q.size(), 0);

        // Two more corrections (one parity-only) push the 2-bit counter to saturation.
        mem[0] = mem[0] ^ 13'h0080;
        mem[3] = mem[3] ^ 13'h0002;
        push(1'b0, 8'd0, '0); push(1'b1, 8'd0, enc(dat[0]));
        push(1'b0, 8'd1, '0); push(1'b0, 8'd2, '0);
        push(1'b0, 8'd3, '0); push(1'b1, 8'd3, enc(dat[3]));
        run_pass();
        check("sat_sbcnt", sb_cnt_o, 3);
        check("sat_parity_fixed", mem[3], enc(dat[3]));
        check("sat_q_empty", exp_q.size(), 0);

        // Reset while the READ of word 1 is stalled.
        ack_hold_adr1 = 1'b1;
        push(1'b0, 8'd0, '0);
        en_i = 1'b1;
        n = 0;
        while (!(mem_req_o === 1'b1 && mem_adr_o == 8'd1) && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        check("stall_reached", mem_adr_o, 1);
        rst_ni = 1'b0;
        en_i = 1'b0;
        @(negedge clk_i);
        check("mrst_req", mem_req_o, 0);
        check("mrst_we", mem_we_o, 0);
        check("mrst_adr", mem_adr_o, 0);
        check("mrst_d", mem_d_o, 0);
        check("mrst_busy", busy_o, 0);
        check("mrst_done", done_o, 0);
        check("mrst_dberr", db_err_o, 0);
        check("mrst_dbadr", db_adr_o, 0);
        check("mrst_sbcnt", sb_cnt_o, 0);
        check("mrst_dbcnt", db_cnt_o, 0);
        check("mrst_decd", dec_d_o, 0);
        rst_ni = 1'b1;
        ack_hold_adr1 = 1'b0;
        @(negedge clk_i);

        // clr_i in the CHECK cycle of a correctable word wins over the increment.
        mem[1] = mem[1] ^ 13'h0200;
        push(1'b0, 8'd0, '0); push(1'b0, 8'd1, '0); push(1'b1, 8'd1, enc(dat[1]));
        push(1'b0, 8'd2, '0); push(1'b0, 8'd3, '0);
        en_i = 1'b1;
        n = 0;
        while (!(busy_o === 1'b1 && mem_req_o === 1'b0 && mem_adr_o == 8'd1 && dec_sb_err_i === 1'b1) && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        check("check_reached", dec_sb_err_i, 1);
        clr_i = 1'b1;
        @(negedge clk_i);
        clr_i = 1'b0;
        check("clr_wins", sb_cnt_o, 0);
        wait_done(n);
        en_i = 1'b0;
        @(negedge clk_i);
        check("clr_sbcnt_final", sb_cnt_o, 0);
        check("clr_mem_fixed", mem[1], enc(dat[1]));
        check("final_q_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
